// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle RV32I/RV32E core sequencing fetch/execute/memory over one shared memory port.
module multicycle_core #(
    parameter int XLEN = 32,
    parameter int NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [3:0]      mem_req_wstrb,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            retire_valid,
    output logic [XLEN-1:0] retire_pc,
    output logic            halted,
    output logic [1:0]      trap_cause
);
    localparam int RW = $clog2(NUM_REGS);
    localparam bit RV32E = (NUM_REGS == 16);

    typedef enum logic [2:0] {FETCH, FETCH_WAIT, EXECUTE, MEM, MEM_WAIT, HALT} state_e;

    state_e state_q, state_d;
    logic [XLEN-1:0] pc_q, ir_q, addr_q, wdata_q;
    logic [3:0] wstrb_q;
    logic we_q;
    logic [1:0] trap_q;
    logic [XLEN-1:0] rf_q [NUM_REGS];

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = ir_q[6:0];
    assign rd = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_fence, is_sys;
    assign is_lui = opcode == 7'b0110111;
    assign is_auipc = opcode == 7'b0010111;
    assign is_jal = opcode == 7'b1101111;
    assign is_jalr = opcode == 7'b1100111;
    assign is_br = opcode == 7'b1100011;
    assign is_ld = opcode == 7'b0000011;
    assign is_st = opcode == 7'b0100011;
    assign is_opi = opcode == 7'b0010011;
    assign is_op = opcode == 7'b0110011;
    assign is_fence = opcode == 7'b0001111;
    assign is_sys = ir_q == 32'h0000_0073 || ir_q == 32'h0010_0073;

    logic ok_opi, ok_op, fmt_ok, uses_rd, uses_rs1, uses_rs2, bad_reg, illegal;
    assign ok_opi = funct3 == 3'b001 ? funct7 == 7'h00 :
                    funct3 == 3'b101 ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
    assign ok_op = funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
    assign fmt_ok = is_lui || is_auipc || is_jal || (is_jalr && funct3 == 3'b000) ||
                    (is_br && funct3[2:1] != 2'b01) ||
                    (is_ld && funct3 != 3'b011 && funct3[2:1] != 2'b11) ||
                    (is_st && funct3[2] == 1'b0 && funct3[1:0] != 2'b11) ||
                    (is_opi && ok_opi) || (is_op && ok_op) || (is_fence && funct3 == 3'b000) || is_sys;
    assign uses_rd = is_lui || is_auipc || is_jal || is_jalr || is_ld || is_opi || is_op;
    assign uses_rs1 = is_jalr || is_br || is_ld || is_st || is_opi || is_op;
    assign uses_rs2 = is_br || is_st || is_op;
    // RV32E only has x0..x15, so any used register field with bit 4 set is illegal
    assign bad_reg = RV32E && ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]));
    assign illegal = !fmt_ok || bad_reg;

    logic [XLEN-1:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j, op_b, alu;
    assign rs1_v = rs1 == 5'd0 ? '0 : rf_q[rs1[RW-1:0]];
    assign rs2_v = rs2 == 5'd0 ? '0 : rf_q[rs2[RW-1:0]];
    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign op_b = is_op ? rs2_v : imm_i;

    logic alt;
    logic [4:0] shamt;
    assign alt = ir_q[30] && (is_op || funct3 == 3'b101);
    assign shamt = op_b[4:0];

    always_comb begin
        case (funct3)
            3'b000: alu = alt ? rs1_v - op_b : rs1_v + op_b;
            3'b001: alu = rs1_v << shamt;
            3'b010: alu = {{(XLEN-1){1'b0}}, $signed(rs1_v) < $signed(op_b)};
            3'b011: alu = {{(XLEN-1){1'b0}}, rs1_v < op_b};
            3'b100: alu = rs1_v ^ op_b;
            3'b101: alu = alt ? XLEN'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
            3'b110: alu = rs1_v | op_b;
            default: alu = rs1_v & op_b;
        endcase
    end

    logic br_cond, jump, pc_mis, mem_mis, is_mem, trap;
    logic [XLEN-1:0] target, next_pc, mem_addr, ex_val, st_data, ld_lane, ld_val, rf_wd;
    logic [3:0] st_strb;
    logic [1:0] cause;
    logic rf_we;
    assign br_cond = funct3[2:1] == 2'b00 ? rs1_v == rs2_v :
                     funct3[2:1] == 2'b10 ? $signed(rs1_v) < $signed(rs2_v) : rs1_v < rs2_v;
    assign jump = is_jal || is_jalr || (is_br && (br_cond ^ funct3[0]));
    assign target = is_jal ? pc_q + imm_j : is_jalr ? (rs1_v + imm_i) & ~XLEN'(1) : pc_q + imm_b;
    assign next_pc = jump ? target : pc_q + XLEN'(4);
    assign pc_mis = jump && target[1:0] != 2'b00;
    assign mem_addr = rs1_v + (is_st ? imm_s : imm_i);
    assign mem_mis = (funct3[1:0] == 2'b01 && mem_addr[0]) || (funct3[1:0] == 2'b10 && mem_addr[1:0] != 2'b00);
    assign is_mem = is_ld || is_st;
    assign trap = illegal || is_sys || (is_mem ? mem_mis : pc_mis);
    assign cause = illegal ? 2'd1 : is_sys ? 2'd0 : 2'd2;
    assign ex_val = is_lui ? imm_u : is_auipc ? pc_q + imm_u : (is_jal || is_jalr) ? pc_q + XLEN'(4) : alu;
    assign st_data = funct3[1:0] == 2'b00 ? {4{rs2_v[7:0]}} : funct3[1:0] == 2'b01 ? {2{rs2_v[15:0]}} : rs2_v;
    assign st_strb = funct3[1:0] == 2'b00 ? 4'b0001 << mem_addr[1:0] :
                     funct3[1:0] == 2'b01 ? 4'b0011 << mem_addr[1:0] : 4'b1111;
    assign ld_lane = mem_resp_rdata >> {addr_q[1:0], 3'b000};
    assign ld_val = funct3 == 3'b000 ? {{24{ld_lane[7]}}, ld_lane[7:0]} :
                    funct3 == 3'b001 ? {{16{ld_lane[15]}}, ld_lane[15:0]} :
                    funct3 == 3'b100 ? {24'b0, ld_lane[7:0]} :
                    funct3 == 3'b101 ? {16'b0, ld_lane[15:0]} : ld_lane;
    assign rf_we = (state_q == EXECUTE && !trap && !is_mem && uses_rd) ||
                   (state_q == MEM_WAIT && mem_resp_valid && is_ld);
    assign rf_wd = state_q == EXECUTE ? ex_val : ld_val;

    always_ff @(posedge clk) begin
        state_q <= reset ? FETCH : state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: state_d = mem_req_ready ? FETCH_WAIT : FETCH;
            FETCH_WAIT: state_d = mem_resp_valid ? EXECUTE : FETCH_WAIT;
            EXECUTE: state_d = trap ? HALT : is_mem ? MEM : FETCH;
            MEM: state_d = mem_req_ready ? MEM_WAIT : MEM;
            MEM_WAIT: state_d = mem_resp_valid ? FETCH : MEM_WAIT;
            default: state_d = HALT;
        endcase
    end

    // Memory request fields come from registers, so they stay stable while stalled
    always_comb begin
        mem_req_valid = !reset && (state_q == FETCH || state_q == MEM);
        mem_req_addr = state_q == MEM ? addr_q : pc_q;
        mem_req_we = state_q == MEM && we_q;
        mem_req_wdata = state_q == MEM ? wdata_q : '0;
        mem_req_wstrb = state_q == MEM ? wstrb_q : 4'b0000;
        retire_valid = !reset && ((state_q == EXECUTE && !trap && !is_mem) ||
                                  (state_q == MEM_WAIT && mem_resp_valid));
        retire_pc = pc_q;
        halted = state_q == HALT;
        trap_cause = trap_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
            ir_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            we_q <= 1'b0;
            trap_q <= 2'd0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            if (state_q == FETCH_WAIT && mem_resp_valid) ir_q <= mem_resp_rdata;
            if (state_q == EXECUTE && trap) trap_q <= cause;
            if (state_q == EXECUTE && !trap && is_mem) begin
                addr_q <= mem_addr;
                we_q <= is_st;
                wdata_q <= is_st ? st_data : '0;
                wstrb_q <= is_st ? st_strb : 4'b0000;
            end
            if (state_q == EXECUTE && !trap && !is_mem) pc_q <= next_pc;
            if (state_q == MEM_WAIT && mem_resp_valid) pc_q <= pc_q + XLEN'(4);
            if (rf_we && rd != 5'd0) rf_q[rd[RW-1:0]] <= rf_wd;
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed bench for multicycle_core with a word-addressed memory model.
module tb_multicycle_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        mem_req_valid, mem_req_we, mem_resp_valid, retire_valid, halted;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata, retire_pc;
    logic [3:0]  mem_req_wstrb;
    logic [1:0]  trap_cause;

    multicycle_core dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .halted(halted), .trap_cause(trap_cause)
    );

    logic        req2_valid, req2_we, resp2_valid = 1'b0, ret2_valid, halted2;
    logic [31:0] req2_addr, req2_wdata, ret2_pc;
    logic [3:0]  req2_wstrb;
    logic [1:0]  trap2;
    logic [31:0] rdata2;
    assign rdata2 = 32'h0010_0893;

    multicycle_core #(.NUM_REGS(16)) dut_e (
        .clk(clk), .reset(reset),
        .mem_req_valid(req2_valid), .mem_req_ready(1'b1), .mem_req_addr(req2_addr),
        .mem_req_we(req2_we), .mem_req_wdata(req2_wdata), .mem_req_wstrb(req2_wstrb),
        .mem_resp_valid(resp2_valid), .mem_resp_rdata(rdata2),
        .retire_valid(ret2_valid), .retire_pc(ret2_pc), .halted(halted2), .trap_cause(trap2)
    );

    always @(posedge clk) resp2_valid <= req2_valid;

    int checks = 0;
    int failures = 0;
    logic rdy = 1'b1;
    int delay = 0;
    assign mem_req_ready = rdy;

    logic [31:0] img [64];
    logic [31:0] mem [64];
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pdata;
    int          acc_n = 0;
    logic [31:0] acc_addr [256];
    logic [31:0] acc_wdata [256];
    logic [3:0]  acc_strb [256];
    logic        acc_we [256];

    // Memory reloads its image during reset; a response pending across reset is still delivered
    always @(posedge clk) begin
        mem_resp_valid <= 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                mem_resp_valid <= 1'b1;
                mem_resp_rdata <= pdata;
                pend <= 1'b0;
            end else cnt <= cnt - 1;
        end
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= img[i];
        end else if (mem_req_valid && mem_req_ready) begin
            if (delay == 0) begin
                mem_resp_valid <= 1'b1;
                mem_resp_rdata <= mem[mem_req_addr[7:2]];
            end else begin
                pend <= 1'b1;
                cnt <= delay - 1;
                pdata <= mem[mem_req_addr[7:2]];
            end
            if (mem_req_we)
                for (int b = 0; b < 4; b++)
                    if (mem_req_wstrb[b]) mem[mem_req_addr[7:2]][8*b +: 8] <= mem_req_wdata[8*b +: 8];
            acc_addr[acc_n] <= mem_req_addr;
            acc_wdata[acc_n] <= mem_req_wdata;
            acc_strb[acc_n] <= mem_req_wstrb;
            acc_we[acc_n] <= mem_req_we;
            acc_n <= acc_n + 1;
        end
    end

    int cyc = 0;
    int ret_n = 0;
    int ret2_n = 0;
    logic [31:0] ret_pc [256];
    int ret_cyc [256];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (retire_valid) begin
            ret_pc[ret_n] <= retire_pc;
            ret_cyc[ret_n] <= cyc;
            ret_n <= ret_n + 1;
        end
        if (ret2_valid) ret2_n <= ret2_n + 1;
    end

    int rb, ab;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 32'h0;
    endtask

    task automatic start();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        rb = ret_n;
        ab = acc_n;
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
        chk(tag, {31'b0, halted}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // ADDI, ADD, ECALL
        clear_img();
        img[0] = 32'h0050_0093;
        img[1] = 32'h0010_8133;
        img[2] = 32'h0000_0073;
        @(negedge clk);
        repeat (2) @(negedge clk);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_retire", {31'b0, retire_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_cause", {30'b0, trap_cause}, 32'd0);
        chk("rst_pc", retire_pc, 32'h0);
        chk("rst_x1", dut.rf_q[1], 32'h0);
        start();
        wait_halt("t1_halt");
        chk("t1_ret_n", ret_n - rb, 32'd2);
        chk("t1_ret_pc0", ret_pc[rb], 32'h0);
        chk("t1_ret_pc1", ret_pc[rb+1], 32'h4);
        chk("t1_ret_gap", ret_cyc[rb+1] - ret_cyc[rb], 32'd3);
        chk("t1_x2", dut.rf_q[2], 32'd10);
        chk("t1_cause", {30'b0, trap_cause}, 32'd0);
        chk("t1_no_more_req", acc_n - ab, 32'd3);

        // JAL x0,+16; ADDI x2,x0,0xF0; SW x2,8(x0); LB x3,8(x0); ECALL
        clear_img();
        img[0] = 32'h0100_006F;
        img[4] = 32'h0F00_0113;
        img[5] = 32'h0020_2423;
        img[6] = 32'h0080_0183;
        img[7] = 32'h0000_0073;
        start();
        wait_halt("t2_halt");
        chk("t2_ret_n", ret_n - rb, 32'd4);
        chk("t2_ret_pc_sw", ret_pc[rb+2], 32'd20);
        chk("t2_ret_pc_lb", ret_pc[rb+3], 32'd24);
        chk("t2_sw_lat", ret_cyc[rb+2] - ret_cyc[rb+1], 32'd5);
        chk("t2_lb_lat", ret_cyc[rb+3] - ret_cyc[rb+2], 32'd5);
        chk("t2_st_we", {31'b0, acc_we[ab+3]}, 32'd1);
        chk("t2_st_addr", acc_addr[ab+3], 32'd8);
        chk("t2_st_wdata", acc_wdata[ab+3], 32'h0000_00F0);
        chk("t2_st_wstrb", {28'b0, acc_strb[ab+3]}, 32'hF);
        chk("t2_ld_we", {31'b0, acc_we[ab+5]}, 32'd0);
        chk("t2_ld_addr", acc_addr[ab+5], 32'd8);
        chk("t2_ld_wstrb", {28'b0, acc_strb[ab+5]}, 32'h0);
        chk("t2_x3", dut.rf_q[3], 32'hFFFF_FFF0);

        // BEQ x0,x0,+8 at 0; JAL x1,+16 at 8; ECALL at 24
        clear_img();
        img[0] = 32'h0000_0463;
        img[2] = 32'h0100_00EF;
        img[6] = 32'h0000_0073;
        start();
        wait_halt("t3_halt");
        chk("t3_fetch1", acc_addr[ab+1], 32'd8);
        chk("t3_fetch2", acc_addr[ab+2], 32'd24);
        chk("t3_x1", dut.rf_q[1], 32'd12);
        chk("t3_ret_pc1", ret_pc[rb+1], 32'd8);
        chk("t3_cause", {30'b0, trap_cause}, 32'd0);

        // fetch stalled by ready low for 4 cycles
        clear_img();
        img[0] = 32'h0050_0093;
        img[1] = 32'h0000_0073;
        rdy = 1'b0;
        start();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_stall_valid", {31'b0, mem_req_valid}, 32'd1);
            chk("t4_stall_addr", mem_req_addr, 32'h0);
        end
        chk("t4_no_accept", acc_n - ab, 32'd0);
        rdy = 1'b1;
        wait_halt("t4_halt");
        chk("t4_accepts", acc_n - ab, 32'd2);
        chk("t4_x1", dut.rf_q[1], 32'd5);
        chk("t4_ret_n", ret_n - rb, 32'd1);

        // illegal word
        clear_img();
        img[0] = 32'hFFFF_FFFF;
        start();
        wait_halt("t5_ill_halt");
        chk("t5_ill_cause", {30'b0, trap_cause}, 32'd1);
        chk("t5_ill_ret", ret_n - rb, 32'd0);

        // LW x1,2(x0): misaligned, no data request
        clear_img();
        img[0] = 32'h0020_2083;
        start();
        wait_halt("t5_mis_halt");
        chk("t5_mis_cause", {30'b0, trap_cause}, 32'd2);
        chk("t5_mis_reqs", acc_n - ab, 32'd1);
        chk("t5_mis_ret", ret_n - rb, 32'd0);

        // reset while a load response is outstanding
        clear_img();
        img[0] = 32'h0080_2083;
        img[1] = 32'h0000_0073;
        img[2] = 32'h1234_5678;
        delay = 3;
        start();
        for (int i = 0; i < 60 && acc_n - ab < 2; i++) @(negedge clk);
        chk("t6_load_issued", acc_n - ab, 32'd2);
        reset = 1'b1;
        rdy = 1'b0;
        @(negedge clk);
        chk("t6_rst_pc", retire_pc, 32'h0);
        chk("t6_rst_valid", {31'b0, mem_req_valid}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_stale_x1", dut.rf_q[1], 32'h0);
        chk("t6_stale_ret", ret_n - rb, 32'd0);
        chk("t6_fetch_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("t6_fetch_addr", mem_req_addr, 32'h0);
        delay = 0;
        rdy = 1'b1;
        wait_halt("t6_halt");
        chk("t6_x1", dut.rf_q[1], 32'h1234_5678);
        chk("t6_ret_n", ret_n - rb, 32'd1);
        chk("t6_cause", {30'b0, trap_cause}, 32'd0);

        // RV32E instance executing ADDI x17,x0,1 since every reset
        chk("t5_e_halted", {31'b0, halted2}, 32'd1);
        chk("t5_e_cause", {30'b0, trap2}, 32'd1);
        chk("t5_e_ret", ret2_n, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
Parametrised multi-cycle RV32I/RV32E integer core, the next generation of the single-cycle datapath. It sequences fetch, execute, memory and writeback through an FSM over a single shared memory port with a valid/ready request channel and a valid response channel. Decode and ALU are internal to the block. It halts cleanly on ECALL/EBREAK, illegal instructions and misaligned accesses, and exposes a retire port for the bench.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
NUM_REGS, 32, architectural register count; 32 selects RV32I, 16 selects RV32E (rd/rs1/rs2 index 16..31 is illegal).
RESET_VECTOR, 32'h0000_0000, PC loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high
mem_req_valid  output  1  request pending
mem_req_ready  input  1  memory accepts request this cycle
mem_req_addr  output  XLEN  byte address, naturally aligned
mem_req_we  output  1  1 = store
mem_req_wdata  output  XLEN  store data, lane-shifted
mem_req_wstrb  output  4  byte enables (all 0 on reads)
mem_resp_valid  input  1  read/write response; exactly one per accepted request, no earlier than the cycle after acceptance
mem_resp_rdata  input  XLEN  read data, full aligned word
retire_valid  output  1  one-cycle pulse per committed instruction
retire_pc  output  XLEN  PC of the retired instruction
halted  output  1  sticky until reset
trap_cause  output  2  0 = ECALL/EBREAK, 1 = illegal, 2 = misaligned; valid while halted

Behaviour:
- Reset values: pc = RESET_VECTOR; state = FETCH; mem_req_valid = 0; retire_valid = 0; halted = 0; trap_cause = 0; all registers = 0.
- Reset is honoured in any state, including with a request outstanding. Any late mem_resp_valid arriving after reset is ignored until a new request is accepted.
- FSM states: FETCH, FETCH_WAIT, EXECUTE, MEM, MEM_WAIT, HALT.
  - FETCH: mem_req_valid = 1, addr = pc, we = 0. On ready go to FETCH_WAIT.
  - FETCH_WAIT: on resp_valid latch ir and go to EXECUTE.
  - EXECUTE: decode and ALU in one cycle.
    - Illegal, or ECALL/EBREAK: go to HALT and set trap_cause; no retire.
    - Load/store: compute the address. If misaligned (half with addr[0] set; word with addr[1:0] nonzero), go to HALT with cause 2. Otherwise go to MEM.
    - Everything else: write rd, update pc, pulse retire, go to FETCH.
  - MEM: drive the request and hold every request field stable until ready. Go to MEM_WAIT.
  - MEM_WAIT: on resp_valid, for loads write the lane-extracted, sign/zero-extended value (LB/LH/LW/LBU/LHU) to rd. Then pc += 4, pulse retire, go to FETCH.
  - HALT: no further requests.
- Request fields must not change while valid && !ready.
- x0 reads 0; writes to x0 are discarded.
- Supported: all RV32I base ops, FENCE treated as NOP. CSR ops are illegal.
- Branches/JAL target = pc + imm. JALR target = (rs1 + imm) & ~1. rd = pc + 4.
- A taken branch/jump to a target with pc[1:0] != 0 is a misaligned trap. pc is not updated and there is no retire.
- Shifts use only operand[4:0]. Arithmetic wraps modulo 2^32.
- Stores: SB writes wdata = rs2[7:0] replicated to all lanes with wstrb = 1 << addr[1:0]. SH writes the halfword replicated with wstrb = 4'b0011 << addr[1:0]. SW uses 4'b1111.
- Latency with zero-wait memory (ready high, response next cycle):
  - ALU/branch/jump: 3 cycles per instruction.
  - Load/store: 5 cycles per instruction.
- retire_valid asserts in the commit cycle with retire_pc = pc of that instruction.

Test Plan:
- Reset to RESET_VECTOR=0. Memory holds 0x00500093 (ADDI x1,x0,5), 0x00108133 (ADD x2,x1,x1), 0x00000073 (ECALL) -> retire_pc 0 then 4, each 3 cycles apart; x2 = 10; halted = 1 with trap_cause 0 and no third retire.
- SW x2,8(x0) (0x00202423) with x2 = 0x000000F0, then LB x3,8(x0) (0x00800183) -> store request addr 8, wstrb 1111, wdata 0xF0; load response 0x000000F0 -> x3 = 0xFFFFFFF0; each instruction takes 5 cycles.
- BEQ x0,x0,+8 (0x00000463) at pc 0 -> next fetch address 8. JAL x1,+16 (0x010000EF) at pc 8 -> x1 = 12, next fetch 24.
- mem_req_ready held low 4 cycles during FETCH -> addr stable all 4 cycles; exactly one FETCH_WAIT transition; correct completion.
- Word 0xFFFFFFFF -> halted, trap_cause 1. LW x1,2(x0) -> halted, trap_cause 2, no memory request issued. With NUM_REGS=16, ADDI x17,x0,1 -> trap_cause 1.
- Reset asserted in MEM_WAIT with a pending response -> next cycle pc = 0 and state FETCH; the stale response does not write rd; normal execution resumes.
